// File: rtl/uart_poll_master.sv
// uart_poll_master: AXI4-Lite polling sequencer for byte-level UART send/receive requests.
// Polls STAT (BASE+8) until RX valid / TX not full, then accesses RX (BASE+0) or TX (BASE+4).
// Define UART_POLL_TIMEOUT_EN to bound the number of status reads per request by TIMEOUT.
module uart_poll_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          POLL_GAP  = 4,
    parameter logic [15:0] TIMEOUT   = 16'hFFFF
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [7:0]  req_wdata_i,
    output logic        resp_valid_o,
    output logic [7:0]  resp_data_o,
    output logic        resp_err_o,
    output logic [31:0] m_axi_araddr_o,
    output logic        m_axi_arvalid_o,
    input  logic        m_axi_arready_i,
    input  logic [31:0] m_axi_rdata_i,
    input  logic [1:0]  m_axi_rresp_i,
    input  logic        m_axi_rvalid_i,
    output logic        m_axi_rready_o,
    output logic [31:0] m_axi_awaddr_o,
    output logic        m_axi_awvalid_o,
    input  logic        m_axi_awready_i,
    output logic [31:0] m_axi_wdata_o,
    output logic [3:0]  m_axi_wstrb_o,
    output logic        m_axi_wvalid_o,
    input  logic        m_axi_wready_i,
    input  logic [1:0]  m_axi_bresp_i,
    input  logic        m_axi_bvalid_i,
    output logic        m_axi_bready_o
);
    typedef enum logic [3:0] {IDLE, ST_AR, ST_R, GAP, RD_AR, RD_R, WR_AW, WR_B, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [7:0]  byte_q, byte_d;
    logic [7:0]  data_q, data_d;
    logic        err_q, err_d;
    logic [15:0] gap_q, gap_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        proceed;
    logic        timed_out;
    logic        unused_bits;

    // Receive waits for RX valid (STAT[0]); transmit waits for TX not full (STAT[3] clear).
    assign proceed = we_q ? !m_axi_rdata_i[3] : m_axi_rdata_i[0];

`ifdef UART_POLL_TIMEOUT_EN
    logic [15:0] poll_q, poll_d;
    assign timed_out   = (poll_q == TIMEOUT);
    assign unused_bits = ^m_axi_rdata_i[31:8];
`else
    assign timed_out   = 1'b0;
    assign unused_bits = ^{m_axi_rdata_i[31:8], TIMEOUT};
`endif

    // State and request context registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            byte_q    <= 8'h00;
            data_q    <= 8'h00;
            err_q     <= 1'b0;
            gap_q     <= 16'h0000;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifdef UART_POLL_TIMEOUT_EN
            poll_q    <= 16'h0000;
`endif
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            byte_q    <= byte_d;
            data_q    <= data_d;
            err_q     <= err_d;
            gap_q     <= gap_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
`ifdef UART_POLL_TIMEOUT_EN
            poll_q    <= poll_d;
`endif
        end
    end

    // Next-state logic: poll STAT, then perform the data-register access and respond.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        byte_d    = byte_q;
        data_d    = data_q;
        err_d     = err_q;
        gap_d     = gap_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
`ifdef UART_POLL_TIMEOUT_EN
        poll_d    = poll_q;
`endif
        case (state_q)
            IDLE: if (req_valid_i) begin
                we_d    = req_we_i;
                byte_d  = req_wdata_i;
                data_d  = 8'h00;
                err_d   = 1'b0;
                state_d = ST_AR;
`ifdef UART_POLL_TIMEOUT_EN
                poll_d  = 16'h0000;
`endif
            end
            ST_AR: if (m_axi_arready_i) state_d = ST_R;
            ST_R: if (m_axi_rvalid_i) begin
`ifdef UART_POLL_TIMEOUT_EN
                poll_d = poll_q + 16'd1;
`endif
                if (m_axi_rresp_i != 2'b00) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (proceed) begin
                    state_d = we_q ? WR_AW : RD_AR;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    gap_d   = 16'h0000;
                    state_d = (POLL_GAP == 0) ? ST_AR : GAP;
                end
            end
            GAP: begin
                gap_d = gap_q + 16'd1;
                if (gap_q == 16'(POLL_GAP - 1)) state_d = ST_AR;
            end
            RD_AR: if (m_axi_arready_i) state_d = RD_R;
            RD_R: if (m_axi_rvalid_i) begin
                err_d   = (m_axi_rresp_i != 2'b00);
                data_d  = (m_axi_rresp_i != 2'b00) ? 8'h00 : m_axi_rdata_i[7:0];
                state_d = RESP;
            end
            WR_AW: begin
                aw_done_d = aw_done_q | m_axi_awready_i;
                w_done_d  = w_done_q | m_axi_wready_i;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_B;
                end
            end
            WR_B: if (m_axi_bvalid_i) begin
                err_d   = (m_axi_bresp_i != 2'b00);
                state_d = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o     = (state_q == IDLE);
    assign resp_valid_o    = (state_q == RESP);
    assign resp_data_o     = (resp_valid_o && !err_q) ? data_q : 8'h00;
    assign resp_err_o      = resp_valid_o && err_q;
    assign m_axi_arvalid_o = (state_q == ST_AR) || (state_q == RD_AR);
    assign m_axi_araddr_o  = (state_q == ST_AR) ? BASE_ADDR + 32'd8 : (state_q == RD_AR) ? BASE_ADDR : 32'h0;
    assign m_axi_rready_o  = (state_q == ST_R) || (state_q == RD_R);
    assign m_axi_awvalid_o = (state_q == WR_AW) && !aw_done_q;
    assign m_axi_wvalid_o  = (state_q == WR_AW) && !w_done_q;
    assign m_axi_awaddr_o  = (state_q == WR_AW) ? BASE_ADDR + 32'd4 : 32'h0;
    assign m_axi_wdata_o   = (state_q == WR_AW) ? {24'h0, byte_q} : 32'h0;
    assign m_axi_wstrb_o   = 4'b0001;
    assign m_axi_bready_o  = (state_q == WR_B);
endmodule

// File: tb/tb_uart_poll_master.sv
// tb_uart_poll_master: directed bench with a behavioural AXI4-Lite UART slave.
module tb_uart_poll_master;
    localparam logic [31:0] BASE = 32'h4000_1000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [7:0]  req_wdata = 8'h00;
    logic        resp_valid, resp_err;
    logic [7:0]  resp_data;
    logic [31:0] araddr, rdata = 32'h0, awaddr, wdata;
    logic        arvalid, arready, rvalid = 1'b0, rready;
    logic [1:0]  rresp = 2'b00, bresp;
    logic        awvalid, awready, wvalid, wready, bvalid = 1'b0, bready;
    logic [3:0]  wstrb;

    uart_poll_master #(.BASE_ADDR(BASE), .POLL_GAP(4), .TIMEOUT(16'd3)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_err_o(resp_err),
        .m_axi_araddr_o(araddr), .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready),
        .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp), .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready),
        .m_axi_awaddr_o(awaddr), .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready),
        .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready),
        .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Slave configuration, written only by the stimulus block.
    logic [7:0]  stat_seq [8];
    int          stat_base = 0;
    logic [1:0]  stat_rresp = 2'b00;
    logic [7:0]  rx_byte = 8'h00;
    int          w_wait = 0;
    logic        b_hold = 1'b0;

    // Slave observation logs, written only by the slave/monitor.
    int          ar_cnt = 0, stat_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic [31:0] ar_log [256];
    int          ar_time [256];
    logic [31:0] aw_addr_last = 32'h0, w_data_last = 32'h0;
    logic [3:0]  w_strb_last = 4'h0;
    int          wcnt = 0;
    logic        aw_pend = 1'b0, w_pend = 1'b0;
    int          aw_v_cyc = 0, w_v_cyc = 0, resp_cnt = 0;
    logic [2:0]  sidx;
    logic        aw_hs, w_hs;

    assign arready = 1'b1;
    assign awready = 1'b1;
    assign wready  = (wcnt >= w_wait);
    assign bresp   = 2'b00;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign sidx    = (stat_cnt - stat_base > 7) ? 3'd7 : 3'(stat_cnt - stat_base);

    always @(posedge clk) begin
        if (!rstn) begin
            rvalid  <= 1'b0;
            bvalid  <= 1'b0;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
            wcnt    <= 0;
        end else begin
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                ar_log[ar_cnt[7:0]]  <= araddr;
                ar_time[ar_cnt[7:0]] <= cyc;
                ar_cnt <= ar_cnt + 1;
                rvalid <= 1'b1;
                if (araddr == BASE + 32'd8) begin
                    rdata    <= {24'h0, stat_seq[sidx]};
                    rresp    <= stat_rresp;
                    stat_cnt <= stat_cnt + 1;
                end else begin
                    rdata <= {24'hABCDEF, rx_byte};
                    rresp <= 2'b00;
                end
            end
            if (wvalid) wcnt <= w_hs ? 0 : wcnt + 1;
            if (aw_hs) begin
                aw_cnt       <= aw_cnt + 1;
                aw_addr_last <= awaddr;
            end
            if (w_hs) begin
                w_cnt       <= w_cnt + 1;
                w_data_last <= wdata;
                w_strb_last <= wstrb;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0;
                b_cnt  <= b_cnt + 1;
            end
            if (!bvalid && !b_hold && (aw_pend || aw_hs) && (w_pend || w_hs)) begin
                bvalid  <= 1'b1;
                aw_pend <= 1'b0;
                w_pend  <= 1'b0;
            end else begin
                if (aw_hs) aw_pend <= 1'b1;
                if (w_hs) w_pend <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (awvalid) aw_v_cyc <= aw_v_cyc + 1;
        if (wvalid) w_v_cyc <= w_v_cyc + 1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill_stat(input logic [7:0] first, input int n_first, input logic [7:0] rest);
        for (int i = 0; i < 8; i++) stat_seq[i] = (i < n_first) ? first : rest;
        stat_base = stat_cnt;
    endtask

    task automatic do_req(input logic we, input logic [7:0] d, output logic [7:0] rd,
                          output logic re, output int lat);
        int acc;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_wdata = d;
        acc       = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 300 && !resp_valid; i++) @(negedge clk);
        chk("resp_seen", {31'h0, resp_valid}, 32'h1);
        rd  = resp_data;
        re  = resp_err;
        lat = cyc - acc;
        @(negedge clk);
    endtask

    function automatic logic [31:0] arl(input int k);
        return ar_log[k[7:0]];
    endfunction

    function automatic int art(input int k);
        return ar_time[k[7:0]];
    endfunction

    initial begin
        logic [7:0] rd;
        logic       re;
        int         lat, a0, aw0, w0, b0, r0, awv0, wv0;
        fill_stat(8'h00, 0, 8'h00);
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_valids", {26'h0, arvalid, rready, awvalid, wvalid, bready, resp_valid}, 32'h0);
        chk("rst_addr", araddr | awaddr | wdata, 32'h0);
        chk("rst_wstrb", {28'h0, wstrb}, 32'h1);
        chk("rst_resp", {23'h0, resp_err, resp_data}, 32'h0);
        rstn = 1'b1;

        // Receive, data ready on first poll, zero-wait slave.
        fill_stat(8'h01, 8, 8'h01);
        rx_byte = 8'h5A;
        a0 = ar_cnt; aw0 = aw_cnt;
        do_req(1'b0, 8'h00, rd, re, lat);
        chk("rx_latency", lat, 5);
        chk("rx_data", {24'h0, rd}, 32'h5A);
        chk("rx_err", {31'h0, re}, 32'h0);
        chk("rx_ar_count", ar_cnt - a0, 2);
        chk("rx_ar0_addr", arl(a0), BASE + 32'h8);
        chk("rx_ar1_addr", arl(a0 + 1), BASE);
        chk("rx_no_write", aw_cnt - aw0, 0);

        // Transmit with TX full for three polls.
        fill_stat(8'h08, 3, 8'h00);
        a0 = ar_cnt; aw0 = aw_cnt;
        do_req(1'b1, 8'h41, rd, re, lat);
        chk("tx_latency", lat, 23);
        chk("tx_stat_reads", ar_cnt - a0, 4);
        for (int k = 1; k < 4; k++) chk("tx_poll_spacing", art(a0 + k) - art(a0 + k - 1), 6);
        chk("tx_aw_count", aw_cnt - aw0, 1);
        chk("tx_awaddr", aw_addr_last, BASE + 32'h4);
        chk("tx_wdata", w_data_last, 32'h41);
        chk("tx_wstrb", {28'h0, w_strb_last}, 32'h1);
        chk("tx_err_data", {23'h0, re, rd}, 32'h0);

        // Transmit with wready delayed three cycles behind awready.
        fill_stat(8'h00, 8, 8'h00);
        w_wait = 3;
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; r0 = resp_cnt; awv0 = aw_v_cyc; wv0 = w_v_cyc;
        do_req(1'b1, 8'h7E, rd, re, lat);
        w_wait = 0;
        chk("wst_latency", lat, 8);
        chk("wst_awvalid_cycles", aw_v_cyc - awv0, 1);
        chk("wst_wvalid_cycles", w_v_cyc - wv0, 4);
        chk("wst_aw_count", aw_cnt - aw0, 1);
        chk("wst_w_count", w_cnt - w0, 1);
        chk("wst_b_count", b_cnt - b0, 1);
        chk("wst_resp_pulses", resp_cnt - r0, 1);
        chk("wst_wdata", w_data_last, 32'h7E);
        chk("wst_err", {31'h0, re}, 32'h0);

        // Status read returns SLVERR.
        fill_stat(8'hFF, 8, 8'hFF);
        stat_rresp = 2'b10;
        a0 = ar_cnt;
        do_req(1'b0, 8'h00, rd, re, lat);
        stat_rresp = 2'b00;
        chk("serr_err", {31'h0, re}, 32'h1);
        chk("serr_data", {24'h0, rd}, 32'h0);
        chk("serr_ar_count", ar_cnt - a0, 1);
        chk("serr_latency", lat, 3);

        // Reset while waiting for B.
        fill_stat(8'h00, 8, 8'h00);
        b_hold = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_wdata = 8'h55;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 50 && !bready; i++) @(negedge clk);
        chk("mid_reached_wr_b", {31'h0, bready}, 32'h1);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        b_hold = 1'b0;
        chk("mid_valids", {26'h0, arvalid, rready, awvalid, wvalid, bready, resp_valid}, 32'h0);
        chk("mid_req_ready", {31'h0, req_ready}, 32'h1);
        fill_stat(8'h01, 8, 8'h01);
        rx_byte = 8'h3C;
        do_req(1'b0, 8'h00, rd, re, lat);
        chk("post_rst_latency", lat, 5);
        chk("post_rst_data", {24'h0, rd}, 32'h3C);
        chk("post_rst_err", {31'h0, re}, 32'h0);

`ifdef UART_POLL_TIMEOUT_EN
        // Status stuck empty: TIMEOUT = 3 allows exactly four reads.
        fill_stat(8'h00, 8, 8'h00);
        a0 = ar_cnt;
        do_req(1'b0, 8'h00, rd, re, lat);
        chk("tmo_stat_reads", ar_cnt - a0, 4);
        chk("tmo_err", {31'h0, re}, 32'h1);
        chk("tmo_data", {24'h0, rd}, 32'h0);
        chk("tmo_latency", lat, 21);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
